fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
// - Sequences the ProgramCounter: drives pc_next_sel/branch_target_addr and runs the instruction-memory fetch handshake.
// - Sits between PC, imem port and decode; one outstanding fetch; hands one instruction at a time to decode (valid/ready).
// - Applies stalls, branch/jump redirects and in-flight flush; keeps a delivered-instruction counter.
// PARAMETERS
// - ADDR_WIDTH   32            PC / imem address width
// - INSTR_WIDTH  32            instruction width
// - TRAP_VECTOR  32'h0000_0100 trap target address (used only with FETCH_SEQ_TRAP_EN)
// PORTS
// - clk                 in   1            clock, all state on posedge
// - rst_n               in   1            reset, asynchronous, active-low
// - start               in   1            leave IDLE and begin fetching (level, sampled in IDLE)
// - pc_in               in   ADDR_WIDTH   current PC (ProgramCounter pc_out)
// - pc_next_sel         out  2            00 = +4, 01 = load branch_target_addr, 10 = hold
// - branch_target_addr  out  ADDR_WIDTH   load address for PC
// - imem_req            out  1            fetch request; imem_addr = pc_in
// - imem_addr           out  ADDR_WIDTH   fetch address
// - imem_gnt            in   1            request accepted this cycle
// - imem_rvalid         in   1            read data valid (>=1 cycle after gnt)
// - imem_rdata          in   INSTR_WIDTH  read data
// - instr_valid         out  1            instr_data/instr_pc valid to decode
// - instr_data          out  INSTR_WIDTH  registered instruction
// - instr_pc            out  ADDR_WIDTH   PC of instr_data
// - instr_ready         in   1            decode accepts instruction
// - stall_in            in   1            suppress new fetch requests
// - redirect_valid      in   1            branch/jump taken (1-cycle pulse)
// - redirect_addr       in   ADDR_WIDTH   redirect target
// - trap_req            in   1            trap pulse (port present only with FETCH_SEQ_TRAP_EN)
// - fetch_count         out  32           delivered instructions, saturates at 32'hFFFF_FFFF
// BEHAVIOUR
// - Reset: state IDLE, pc_next_sel=10, branch_target_addr=0, imem_req=0, instr_valid=0, instr_data=0, instr_pc=0, flush=0, fetch_count=0.
// - States: IDLE, REQ, WAIT, HOLD. IDLE -> REQ when start=1; otherwise pc_next_sel=10.
// - REQ: imem_req = !stall_in && !redirect_valid. On imem_req && imem_gnt -> WAIT, latch instr_pc <= pc_in. pc_next_sel=10.
// - WAIT: imem_req=0. On imem_rvalid: flush=0 -> instr_data <= imem_rdata, instr_valid <= 1, go HOLD. flush=1 -> drop data, flush <= 0, go REQ.
// - HOLD: instr_valid=1, outputs stable. On instr_ready: pc_next_sel=00 combinationally that cycle, instr_valid <= 0,
//   fetch_count++ (saturating), go REQ. The PC is +4 at the same edge, so the next REQ uses the new pc_in.
// - Redirect (any state except IDLE), highest priority:
//   - pc_next_sel=01 and branch_target_addr=redirect_addr that cycle (combinational).
//   - instr_valid <= 0; an instruction in HOLD is discarded and not counted, even with instr_ready=1.
//   - In WAIT with no rvalid that cycle: flush <= 1, stay WAIT. In WAIT with rvalid the same cycle: drop data, go REQ. Otherwise go REQ.
// - Redirect in REQ with imem_gnt high is ignored by imem: imem_req is forced 0, so no grant is taken.
// - Redirect in IDLE is ignored (pc_next_sel=10).
// - branch_target_addr holds its last value when pc_next_sel != 01.
// - Stall: affects REQ only. In HOLD/WAIT stall_in has no effect.
// - Latency: REQ-grant to instr_valid = imem latency + 1 cycle (registered output); min. fetch-to-fetch = 3 cycles with 1-cycle imem.
// - Reset mid-operation: immediate return to reset values; a pending imem response after reset is ignored (state IDLE).
// CONFIGURATION
// - FETCH_SEQ_TRAP_EN defined: trap_req port exists and has priority over redirect_valid.
//   - Identical flush/discard semantics, with branch_target_addr = TRAP_VECTOR and pc_next_sel=01.
//   - Simultaneous trap+redirect: trap wins, redirect dropped.
// - FETCH_SEQ_TRAP_EN undefined: no trap_req port, TRAP_VECTOR unused, redirect is the highest priority.
// TESTING
// - Reset, start=1, pc_in=0, 1-cycle imem, instr_ready=1 -> imem_addr 0,4,8 in order; instr_pc 0,4,8; fetch_count=3; pc_next_sel=00 once per instr.
// - Redirect to 0x200 while in WAIT -> pc_next_sel=01 / branch_target_addr=0x200 for 1 cycle; next rvalid dropped (instr_valid stays 0); next imem_addr=0x200.
// - instr_valid=1 at pc 0x10, instr_ready=0 for 5 cycles -> instr_data/instr_pc stable, pc_next_sel=10, imem_req=0, fetch_count unchanged.
// - stall_in=1 for 4 cycles in REQ -> imem_req=0 throughout; after release, request issued at unchanged pc_in.
// - Redirect and instr_ready same cycle in HOLD -> pc_next_sel=01 (not 00), fetch_count not incremented, instr_valid=0 next cycle.
// - FETCH_SEQ_TRAP_EN: trap_req and redirect_valid(0x300) same cycle -> branch_target_addr=0x100, next imem_addr=0x100; rst_n low mid-WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction-memory request/response port plus the decode hand-off.
// master = sequencer side, slave = imem/decode side.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_gnt;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic                   instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer and single-outstanding imem fetch engine handing one instruction at a time to decode.
// Optional trap redirect to TRAP_VECTOR is enabled by defining FETCH_SEQ_TRAP_EN.
module fetch_sequencer #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = ADDR_WIDTH'(32'h0000_0100)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic [1:0]            pc_next_sel,
  output logic [ADDR_WIDTH-1:0] branch_target_addr,
  fetch_sequencer_if.master     bus,
  input  logic                  stall_in,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
`ifdef FETCH_SEQ_TRAP_EN
  input  logic                  trap_req,
`endif
  output logic [31:0]           fetch_count
);

  localparam int unsigned CNT_WIDTH = 32;
  localparam logic [1:0]  SEL_INC   = 2'b00;
  localparam logic [1:0]  SEL_LOAD  = 2'b01;
  localparam logic [1:0]  SEL_HOLD  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t                 state_q, state_d;
  logic                   flush_q, flush_d;
  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0]  ipc_q, ipc_d;
  logic [ADDR_WIDTH-1:0]  btarget_q, btarget_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;

  logic                   trap_c;
  logic                   evt_c;
  logic [ADDR_WIDTH-1:0]  target_c;

  // Trap source; tied off when the trap feature is not built.
`ifdef FETCH_SEQ_TRAP_EN
  assign trap_c = trap_req;
`else
  assign trap_c = 1'b0;
`endif

  // Redirect events are ignored while idle; a trap overrides a concurrent redirect.
  assign evt_c    = (state_q != S_IDLE) && (trap_c || redirect_valid);
  assign target_c = trap_c ? TRAP_VECTOR : redirect_addr;

  assign bus.imem_addr   = pc_in;
  assign bus.instr_valid = valid_q;
  assign bus.instr_data  = data_q;
  assign bus.instr_pc    = ipc_q;
  assign fetch_count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      flush_q   <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      ipc_q     <= '0;
      btarget_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ipc_q     <= ipc_d;
      btarget_q <= btarget_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    flush_d            = flush_q;
    valid_d            = valid_q;
    data_d             = data_q;
    ipc_d              = ipc_q;
    btarget_d          = btarget_q;
    count_d            = count_q;
    pc_next_sel        = SEL_HOLD;
    branch_target_addr = btarget_q;
    bus.imem_req       = 1'b0;

    // Redirect outranks every per-state action, including a pending decode accept.
    if (evt_c) begin
      pc_next_sel        = SEL_LOAD;
      branch_target_addr = target_c;
      btarget_d          = target_c;
      valid_d            = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ;
      end

      S_REQ: begin
        bus.imem_req = !stall_in && !evt_c;
        if (bus.imem_req && bus.imem_gnt) begin
          ipc_d   = pc_in;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (evt_c) begin
          if (bus.imem_rvalid) begin
            flush_d = 1'b0;
            state_d = S_REQ;
          end else begin
            flush_d = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          if (flush_q) begin
            flush_d = 1'b0;
            state_d = S_REQ;
          end else begin
            data_d  = bus.imem_rdata;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (evt_c) begin
          state_d = S_REQ;
        end else if (bus.instr_ready) begin
          pc_next_sel = SEL_INC;
          valid_d     = 1'b0;
          count_d     = (count_q == '1) ? count_q : count_q + CNT_WIDTH'(1);
          state_d     = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level fetch model.
module tb_fetch_sequencer;

  localparam logic [1:0] SEL_INC  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_HOLD = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] pc_in;
  logic [1:0]  pc_next_sel;
  logic [31:0] branch_target_addr;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic [31:0] fetch_count;
`ifdef FETCH_SEQ_TRAP_EN
  logic        trap_req;
`endif

  fetch_sequencer_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  fetch_sequencer #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .pc_in              (pc_in),
    .pc_next_sel        (pc_next_sel),
    .branch_target_addr (branch_target_addr),
    .bus                (bus),
    .stall_in           (stall_in),
    .redirect_valid     (redirect_valid),
    .redirect_addr      (redirect_addr),
`ifdef FETCH_SEQ_TRAP_EN
    .trap_req           (trap_req),
`endif
    .fetch_count        (fetch_count)
  );

  always #5 clk = ~clk;

  // ProgramCounter stand-in, steered by the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_in <= 32'd0;
    else begin
      case (pc_next_sel)
        SEL_INC:  pc_in <= pc_in + 32'd4;
        SEL_LOAD: pc_in <= branch_target_addr;
        default:  ;
      endcase
    end
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic zero_inputs();
    start          = 1'b0;
    stall_in       = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'd0;
    bus.imem_gnt   = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.instr_ready = 1'b0;
`ifdef FETCH_SEQ_TRAP_EN
    trap_req       = 1'b0;
`endif
  endtask

  task automatic cyc();
    @(negedge clk);
    zero_inputs();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sel"},   32'(pc_next_sel), 32'(SEL_HOLD));
    check({tag, "_bta"},   branch_target_addr, 32'd0);
    check({tag, "_req"},   32'(bus.imem_req), 32'd0);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_idata"}, bus.instr_data, 32'd0);
    check({tag, "_ipc"},   bus.instr_pc, 32'd0);
    check({tag, "_count"}, fetch_count, 32'd0);
  endtask

  // in = {start, gnt, rvalid, ready, stall, redirect}
  typedef struct {
    logic [5:0]  in;
    logic [31:0] rdata;
    logic [31:0] raddr;
    logic        req;
    logic [31:0] addr;
    logic [1:0]  sel;
    logic [31:0] bta;
    logic        valid;
    logic [31:0] ipc;
    logic [31:0] idata;
    logic [31:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] in, input logic [31:0] rdata, input logic [31:0] raddr,
                              input logic req, input logic [31:0] addr, input logic [1:0] sel,
                              input logic [31:0] bta, input logic valid, input logic [31:0] ipc,
                              input logic [31:0] idata, input logic [31:0] cnt);
    vec_t v;
    v.in = in; v.rdata = rdata; v.raddr = raddr; v.req = req; v.addr = addr; v.sel = sel;
    v.bta = bta; v.valid = valid; v.ipc = ipc; v.idata = idata; v.cnt = cnt;
    return v;
  endfunction

  task automatic run_vec(input int i, input vec_t v);
    cyc();
    {start, bus.imem_gnt, bus.imem_rvalid, bus.instr_ready, stall_in, redirect_valid} = v.in;
    bus.imem_rdata = v.rdata;
    redirect_addr  = v.raddr;
    #2;
    check($sformatf("vec%0d_req", i), 32'(bus.imem_req), 32'(v.req));
    if (v.req) check($sformatf("vec%0d_addr", i), bus.imem_addr, v.addr);
    check($sformatf("vec%0d_sel", i), 32'(pc_next_sel), 32'(v.sel));
    check($sformatf("vec%0d_bta", i), branch_target_addr, v.bta);
    check($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(v.valid));
    if (v.valid) begin
      check($sformatf("vec%0d_ipc", i), bus.instr_pc, v.ipc);
      check($sformatf("vec%0d_idata", i), bus.instr_data, v.idata);
    end
    check($sformatf("vec%0d_count", i), fetch_count, v.cnt);
  endtask

  // Transaction-level model: what decode should see, which fetch is in flight, where the PC should be.
  logic        m_act, m_valid, m_pend, m_stale;
  logic [31:0] m_pc, m_data, m_paddr, m_fpc, m_bta, m_count;
  int unsigned resp_cnt = 0;
  logic [31:0] resp_addr = 32'd0;

  task automatic model_reset();
    m_act = 1'b0; m_valid = 1'b0; m_pend = 1'b0; m_stale = 1'b0;
    m_pc = 32'd0; m_data = 32'd0; m_paddr = 32'd0; m_fpc = 32'd0; m_bta = 32'd0; m_count = 32'd0;
  endtask

  vec_t tbl [18];

  initial begin
    logic        redir, deliver, exp_req;
    logic [1:0]  exp_sel;

    tbl[0]  = mk(6'b100000, 32'h0,         32'h0,   1'b0, 32'h0,   SEL_HOLD, 32'h0,   1'b0, 32'h0,   32'h0,         32'd0);
    tbl[1]  = mk(6'b010000, 32'h0,         32'h0,   1'b1, 32'h0,   SEL_HOLD, 32'h0,   1'b0, 32'h0,   32'h0,         32'd0);
    tbl[2]  = mk(6'b001000, 32'hA000_0000, 32'h0,   1'b0, 32'h0,   SEL_HOLD, 32'h0,   1'b0, 32'h0,   32'h0,         32'd0);
    tbl[3]  = mk(6'b000100, 32'h0,         32'h0,   1'b0, 32'h0,   SEL_INC,  32'h0,   1'b1, 32'h0,   32'hA000_0000, 32'd0);
    tbl[4]  = mk(6'b010000, 32'h0,         32'h0,   1'b1, 32'h4,   SEL_HOLD, 32'h0,   1'b0, 32'h0,   32'h0,         32'd1);
    tbl[5]  = mk(6'b001000, 32'hA000_0004, 32'h0,   1'b0, 32'h0,   SEL_HOLD, 32'h0,   1'b0, 32'h0,   32'h0,         32'd1);
    tbl[6]  = mk(6'b000100, 32'h0,         32'h0,   1'b0, 32'h0,   SEL_INC,  32'h0,   1'b1, 32'h4,   32'hA000_0004, 32'd1);
    tbl[7]  = mk(6'b010000, 32'h0,         32'h0,   1'b1, 32'h8,   SEL_HOLD, 32'h0,   1'b0, 32'h0,   32'h0,         32'd2);
    tbl[8]  = mk(6'b001000, 32'hA000_0008, 32'h0,   1'b0, 32'h0,   SEL_HOLD, 32'h0,   1'b0, 32'h0,   32'h0,         32'd2);
    tbl[9]  = mk(6'b000100, 32'h0,         32'h0,   1'b0, 32'h0,   SEL_INC,  32'h0,   1'b1, 32'h8,   32'hA000_0008, 32'd2);
    tbl[10] = mk(6'b010000, 32'h0,         32'h0,   1'b1, 32'hC,   SEL_HOLD, 32'h0,   1'b0, 32'h0,   32'h0,         32'd3);
    tbl[11] = mk(6'b000001, 32'h0,         32'h200, 1'b0, 32'h0,   SEL_LOAD, 32'h200, 1'b0, 32'h0,   32'h0,         32'd3);
    tbl[12] = mk(6'b001000, 32'hDEAD_BEEF, 32'h0,   1'b0, 32'h0,   SEL_HOLD, 32'h200, 1'b0, 32'h0,   32'h0,         32'd3);
    tbl[13] = mk(6'b000000, 32'h0,         32'h0,   1'b1, 32'h200, SEL_HOLD, 32'h200, 1'b0, 32'h0,   32'h0,         32'd3);
    tbl[14] = mk(6'b010000, 32'h0,         32'h0,   1'b1, 32'h200, SEL_HOLD, 32'h200, 1'b0, 32'h0,   32'h0,         32'd3);
    tbl[15] = mk(6'b001000, 32'hA000_0200, 32'h0,   1'b0, 32'h0,   SEL_HOLD, 32'h200, 1'b0, 32'h0,   32'h0,         32'd3);
    tbl[16] = mk(6'b000101, 32'h0,         32'h300, 1'b0, 32'h0,   SEL_LOAD, 32'h300, 1'b1, 32'h200, 32'hA000_0200, 32'd3);
    tbl[17] = mk(6'b000000, 32'h0,         32'h0,   1'b1, 32'h300, SEL_HOLD, 32'h300, 1'b0, 32'h0,   32'h0,         32'd3);

    rst_n = 1'b0;
    zero_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #2;
    check_reset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) run_vec(i, tbl[i]);

    // Stall held for four cycles in REQ, then released at the same PC.
    for (int k = 0; k < 4; k++) begin
      cyc(); stall_in = 1'b1; bus.imem_gnt = 1'b1; #2;
      check("stall_req", 32'(bus.imem_req), 32'd0);
      check("stall_sel", 32'(pc_next_sel), 32'(SEL_HOLD));
    end
    cyc(); bus.imem_gnt = 1'b1; #2;
    check("stall_rel_req", 32'(bus.imem_req), 32'd1);
    check("stall_rel_addr", bus.imem_addr, 32'h300);
    cyc(); bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA000_0300; #2;
    cyc(); redirect_valid = 1'b1; redirect_addr = 32'h10; #2;
    check("hold_redir_sel", 32'(pc_next_sel), 32'(SEL_LOAD));
    check("hold_redir_valid", 32'(bus.instr_valid), 32'd1);
    cyc(); bus.imem_gnt = 1'b1; #2;
    check("redir10_addr", bus.imem_addr, 32'h10);
    check("redir10_valid", 32'(bus.instr_valid), 32'd0);
    cyc(); bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA000_0010; #2;

    // Decode back-pressure: everything must hold still.
    for (int k = 0; k < 5; k++) begin
      cyc(); #2;
      check("bp_valid", 32'(bus.instr_valid), 32'd1);
      check("bp_ipc", bus.instr_pc, 32'h10);
      check("bp_idata", bus.instr_data, 32'hA000_0010);
      check("bp_sel", 32'(pc_next_sel), 32'(SEL_HOLD));
      check("bp_req", 32'(bus.imem_req), 32'd0);
      check("bp_count", fetch_count, 32'd3);
    end
    cyc(); bus.instr_ready = 1'b1; #2;
    check("bp_accept_sel", 32'(pc_next_sel), 32'(SEL_INC));
    cyc(); bus.imem_gnt = 1'b1; #2;
    check("bp_after_count", fetch_count, 32'd4);
    check("bp_after_addr", bus.imem_addr, 32'h14);
    check("bp_after_valid", 32'(bus.instr_valid), 32'd0);

    // Asynchronous reset while a fetch is outstanding; late response must be ignored.
    cyc(); #1; rst_n = 1'b0; #1;
    check_reset("midwait_rst");
    cyc(); rst_n = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0BAD_C0DE; bus.imem_gnt = 1'b1; #2;
    check("late_rsp_req0", 32'(bus.imem_req), 32'd0);
    cyc(); #2;
    check("late_rsp_valid", 32'(bus.instr_valid), 32'd0);
    check("late_rsp_req1", 32'(bus.imem_req), 32'd0);

`ifdef FETCH_SEQ_TRAP_EN
    cyc(); start = 1'b1; #2;
    cyc(); trap_req = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h300; bus.imem_gnt = 1'b1; #2;
    check("trap_sel", 32'(pc_next_sel), 32'(SEL_LOAD));
    check("trap_bta", branch_target_addr, 32'h100);
    check("trap_req_blk", 32'(bus.imem_req), 32'd0);
    cyc(); bus.imem_gnt = 1'b1; #2;
    check("trap_next_req", 32'(bus.imem_req), 32'd1);
    check("trap_next_addr", bus.imem_addr, 32'h100);
`endif

    // Randomized run against the transaction model.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (n == 0 || $urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #2;
        check("rnd_rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rnd_rst_count", fetch_count, 32'd0);
        model_reset();
        if (resp_cnt > 0) resp_cnt--;
      end else begin
        rst_n           = 1'b1;
        start           = ($urandom_range(0, 3) == 0);
        stall_in        = ($urandom_range(0, 3) == 0);
        redirect_valid  = ($urandom_range(0, 9) == 0);
        redirect_addr   = 32'($urandom_range(0, 1023)) << 2;
        bus.instr_ready = ($urandom_range(0, 9) < 6);
        bus.imem_gnt    = ($urandom_range(0, 9) < 6);
        bus.imem_rvalid = (resp_cnt == 1);
        bus.imem_rdata  = bus.imem_rvalid ? mem_word(resp_addr) : 32'($urandom());
        #2;
        redir   = m_act && redirect_valid;
        deliver = m_valid && bus.instr_ready && !redir;
        exp_req = m_act && !m_pend && !m_valid && !stall_in && !redir;
        exp_sel = redir ? SEL_LOAD : (deliver ? SEL_INC : SEL_HOLD);
        check("rnd_sel", 32'(pc_next_sel), 32'(exp_sel));
        check("rnd_bta", branch_target_addr, redir ? redirect_addr : m_bta);
        check("rnd_req", 32'(bus.imem_req), 32'(exp_req));
        if (exp_req) check("rnd_addr", bus.imem_addr, m_fpc);
        check("rnd_valid", 32'(bus.instr_valid), 32'(m_valid));
        if (m_valid) begin
          check("rnd_ipc", bus.instr_pc, m_pc);
          check("rnd_idata", bus.instr_data, m_data);
        end
        check("rnd_count", fetch_count, m_count);

        if (!m_act) begin
          m_act = start;
        end else begin
          if (exp_req && bus.imem_gnt) begin
            m_pend = 1'b1; m_paddr = m_fpc; m_stale = 1'b0;
          end else if (m_pend && bus.imem_rvalid) begin
            if (!m_stale && !redir) begin
              m_valid = 1'b1; m_pc = m_paddr; m_data = mem_word(m_paddr);
            end
            m_pend = 1'b0; m_stale = 1'b0;
          end else if (m_pend && redir) begin
            m_stale = 1'b1;
          end
          if (deliver) begin
            m_valid = 1'b0;
            m_count = (m_count == 32'hFFFF_FFFF) ? m_count : m_count + 32'd1;
            m_fpc   = m_fpc + 32'd4;
          end
          if (redir) begin
            m_valid = 1'b0; m_bta = redirect_addr; m_fpc = redirect_addr;
          end
        end

        if (resp_cnt > 0) resp_cnt--;
        if (bus.imem_req && bus.imem_gnt) begin
          resp_cnt  = $urandom_range(1, 3);
          resp_addr = bus.imem_addr;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
